sar_result_reader: RTL and testbench
====================================

Name: sar_result_reader

Overview:
- Consumer end of the SAR conversion interface: gates the SAR controller's ENABLE, detects each end-of-conversion (EOC), captures the 12-bit DOUT word and buffers it in a small FIFO.
- Presents results on a valid/ready stream toward the digital side (Caravel/wishbone glue).
- Supports single bursts of N conversions or continuous running.
- Sits between sar_controller and the readout logic, on the same CLK.

Parameters:
- DEPTH, 8, FIFO depth in words; power of two, 2..64.
- CNT_W, 16, width of burst-length counter and NUM_SAMPLES.

Ports:
- CLK  input  1  system clock; same clock as sar_controller.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle pulse; begins a burst when IDLE.
- STOP  input  1  one-cycle pulse; aborts RUN.
- CONT  input  1  1 = continuous mode; NUM_SAMPLES is ignored.
- NUM_SAMPLES  input  CNT_W  results per burst; 0 is treated as 1.
- EOC  input  1  end of conversion from sar_controller.
- DOUT  input  [0:11]  conversion result; DOUT[0] is the LSB (weight 1), DOUT[11] the MSB (weight 2048).
- ADC_ENABLE  output  1  drives sar_controller ENABLE.
- DATA_OUT  output  [11:0]  FIFO head; DATA_OUT[i] = captured DOUT[i].
- VALID  output  1  FIFO not empty.
- READY  input  1  consumer accepts DATA_OUT when VALID && READY at a CLK edge.
- BUSY  output  1  state != IDLE.
- BURST_DONE  output  1  one-cycle pulse at end of burst.
- OVF  output  1  sticky overflow flag.
- LEVEL  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: all state is synchronous on RST=1. Reset values:
  - ADC_ENABLE=0, BUSY=0, BURST_DONE=0, OVF=0, VALID=0, LEVEL=0, DATA_OUT=0.
  - Pointers and counters = 0; eoc_d=0; FSM=IDLE.
  - RST mid-burst discards FIFO contents.
- EOC edge detect: eoc_d registers EOC each cycle. A conversion event is EOC=1 && eoc_d=0 sampled at a CLK edge, and is accepted only in RUN. A level held high for several cycles yields exactly one event.
- FSM states and transitions:
  - IDLE: ADC_ENABLE=0. START → RUN. Also on START: clear the sample counter and OVF. FIFO contents are kept.
  - RUN: ADC_ENABLE=1.
    - Each event pushes DOUT and increments the counter.
    - If CONT=0 and the counter reaches max(NUM_SAMPLES,1) on this event → DONE.
    - STOP → IDLE, with no BURST_DONE. A result whose EOC rises in the same cycle as STOP is still pushed.
    - START is ignored.
  - DONE: one cycle. BURST_DONE=1 and ADC_ENABLE=0, then → IDLE.
  - CONT or NUM_SAMPLES changes during RUN take effect at the next event comparison.
- FIFO is first-word-fall-through:
  - A push at edge k gives VALID=1 and DATA_OUT=word from the cycle after edge k (1-cycle latency).
  - Pop on VALID && READY; DATA_OUT advances to the next word in the following cycle.
  - DATA_OUT holds its last value when the FIFO is empty.
- Boundary conditions:
  - Full with no pop: the event is dropped, OVF←1, and the counter still increments (conversions are counted, not stored).
  - Full with a simultaneous pop: both happen and LEVEL is unchanged.
  - Empty with a push: only the push happens; READY while VALID=0 is ignored.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The counter saturates at 2^CNT_W−1 in CONT mode.
- OVF is sticky; it is cleared only by RST or by START accepted in IDLE.

Optional Feature:
- Macro: SAR_READER_AVG_EN.
- Defined:
  - Adds parameter AVG_LOG2 (default 2) and a (12+AVG_LOG2)-bit accumulator.
  - Each event adds DOUT. After 2^AVG_LOG2 events, push accumulator>>AVG_LOG2 (truncate) and clear the accumulator.
  - The sample counter and NUM_SAMPLES count averaged pushes.
  - STOP or RST discards a partial accumulation; START clears it.
- Undefined: every event pushes the raw DOUT, as described above. No accumulator logic is present.

Test Plan:
- Single burst: RST, NUM_SAMPLES=3, CONT=0, START; drive EOC pulses with DOUT=12'h800, 12'h001, 12'hFFF; READY=1 → ADC_ENABLE=1 from the cycle after START. DATA_OUT reads 800, 001, FFF in order; each word is VALID 1 cycle after its EOC edge. BURST_DONE pulses once and ADC_ENABLE=0 after the 3rd event.
- EOC held high 5 cycles with DOUT=12'h0A5 → exactly one push; LEVEL=1.
- Overflow: DEPTH=8, READY=0, CONT=1, 10 events with values 0..9 → LEVEL=8, OVF=1; drain yields 0..7. A following START clears OVF.
- Simultaneous push and pop at full: LEVEL=8, READY=1, event with 12'h123 → LEVEL stays 8 and 12'h123 is the last word drained.
- STOP and reset mid-burst: NUM_SAMPLES=10, STOP after 4 events → IDLE, no BURST_DONE, 4 words available. RST asserted mid-RUN → all outputs at reset values next cycle.
- With SAR_READER_AVG_EN and AVG_LOG2=2: events 100, 101, 102, 103 → single push of 101 (406>>2). NUM_SAMPLES=1 ends the burst after that push.

Source files
------------

// File: rtl/sar_result_reader.sv
// sar_result_reader: consumer side of the SAR conversion interface.
// Gates the SAR controller ENABLE, edge-detects EOC, captures DOUT and
// buffers results in a first-word-fall-through FIFO. The FIFO feeds a
// valid/ready stream.
// Optional feature: define SAR_READER_AVG_EN to average 2^AVG_LOG2
// conversions per pushed word.
//
// Stream handshake: VALID means DATA_OUT holds the FIFO head. A word is
// consumed at a CLK edge where VALID && READY. VALID never depends on READY,
// and READY while VALID=0 has no effect.
module sar_result_reader #(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
`ifdef SAR_READER_AVG_EN
  ,
  parameter int AVG_LOG2 = 2
`endif
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       CONT,
  input  logic [CNT_W-1:0]           NUM_SAMPLES,
  input  logic                       EOC,
  input  logic [0:11]                DOUT,
  output logic                       ADC_ENABLE,
  output logic [11:0]                DATA_OUT,
  output logic                       VALID,
  input  logic                       READY,
  output logic                       BUSY,
  output logic                       BURST_DONE,
  output logic                       OVF,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic [1:0]                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             eoc_d;
  logic [11:0]      din;
  logic             ev;
  logic             push_req;
  logic [11:0]      push_data;
  logic [CNT_W-1:0] target;
  logic [CNT_W:0]   cnt_inc;
  logic             burst_hit;

  logic [11:0]      mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_p1;
  logic [LW-1:0]    level;
  logic [11:0]      data_out;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // DOUT is declared [0:11] with DOUT[0] as LSB; map bit-for-bit by index
  always_comb begin
    din = '0;
    for (int i = 0; i < 12; i++) din[i] = DOUT[i];
  end

  // Registered copy of EOC for rising-edge detection
  always_ff @(posedge CLK) begin
    if (RST) eoc_d <= 1'b0;
    else     eoc_d <= EOC;
  end

  assign ev = EOC && !eoc_d && (state == ST_RUN);

`ifdef SAR_READER_AVG_EN
  logic [12+AVG_LOG2-1:0] acc;
  logic [12+AVG_LOG2-1:0] acc_sum;
  logic [AVG_LOG2-1:0]    acc_cnt;

  assign acc_sum   = acc + (12+AVG_LOG2)'(din);
  assign push_req  = ev && (&acc_cnt);
  assign push_data = acc_sum[AVG_LOG2 +: 12];

  // Accumulate conversions; a full group is pushed and the sum restarts.
  // STOP drops any partial group, START begins a fresh one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (state == ST_IDLE && START) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (state == ST_RUN && STOP) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (ev) begin
      if (&acc_cnt) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end
`else
  assign push_req  = ev;
  assign push_data = din;
`endif

  // Burst end test uses a widened increment so it never wraps
  assign target    = (NUM_SAMPLES == '0) ? CNT_W'(1) : NUM_SAMPLES;
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
  assign burst_hit = !CONT && push_req && (cnt_inc >= {1'b0, target});

  assign full    = (level == LW'(DEPTH));
  assign pop     = VALID && READY;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Control FSM, sample counter and sticky overflow flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_RUN;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (push_req && (cnt != '1)) cnt <= cnt + 1'b1;
          if (drop) ovf <= 1'b1;
          // STOP takes priority over a burst completing on the same edge
          if (STOP)           state <= ST_IDLE;
          else if (burst_hit) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign rd_ptr_p1 = rd_ptr + 1'b1;

  // FIFO pointers, occupancy and registered head word
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      data_out <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr_p1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Head update: an empty FIFO shows the incoming word directly; a pop
      // exposes the next stored word, or the incoming one if it was the last.
      // With nothing to show, the previous word is held.
      if (level == '0) begin
        if (push_ok) data_out <= push_data;
      end else if (pop) begin
        if (level >= LW'(2)) data_out <= mem[rd_ptr_p1];
        else if (push_ok)    data_out <= push_data;
      end
    end
  end

  assign ADC_ENABLE = (state == ST_RUN);
  assign BUSY       = (state != ST_IDLE);
  assign BURST_DONE = (state == ST_DONE);
  assign OVF        = ovf;
  assign VALID      = (level != '0);
  assign LEVEL      = level;
  assign DATA_OUT   = data_out;
  assign dbg_state  = state;

endmodule

// File: tb/tb_sar_result_reader.sv
// Directed testbench for sar_result_reader (DEPTH=8, CNT_W=16).
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_sar_result_reader;

  localparam int CLK_NS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cont;
  logic [15:0] num_samples;
  logic        eoc;
  logic [0:11] dout;
  logic        adc_enable;
  logic [11:0] data_out;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        burst_done;
  logic        ovf;
  logic [3:0]  level;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int fails     = 0;
  int bd_count  = 0;
  logic [11:0] exp_q[$];

  sar_result_reader #(.DEPTH(8), .CNT_W(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .STOP       (stop),
    .CONT       (cont),
    .NUM_SAMPLES(num_samples),
    .EOC        (eoc),
    .DOUT       (dout),
    .ADC_ENABLE (adc_enable),
    .DATA_OUT   (data_out),
    .VALID      (valid),
    .READY      (ready),
    .BUSY       (busy),
    .BURST_DONE (burst_done),
    .OVF        (ovf),
    .LEVEL      (level),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #(CLK_NS/2) clk = ~clk;

  initial begin
    #(100000 * CLK_NS);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Count BURST_DONE pulses over the whole run
  always @(posedge clk) begin
    if (burst_done) bd_count <= bd_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // DOUT[i] carries weight 2^i
  task automatic set_dout(input logic [11:0] v);
    for (int i = 0; i < 12; i++) dout[i] = v[i];
  endtask

  task automatic eoc_on(input logic [11:0] v);
    set_dout(v);
    eoc = 1'b1;
    tick();
  endtask

  task automatic eoc_off();
    eoc = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_adc"},   32'(adc_enable), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_bdone"}, 32'(burst_done), 32'd0);
    check({tag, "_ovf"},   32'(ovf),        32'd0);
    check({tag, "_valid"}, 32'(valid),      32'd0);
    check({tag, "_level"}, 32'(level),      32'd0);
    check({tag, "_data"},  32'(data_out),   32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    num_samples = 16'd0; eoc = 1'b0; ready = 1'b0;
    set_dout(12'h000);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("reset");

    // Single burst of 3, READY held high
    num_samples = 16'd3; cont = 1'b0; ready = 1'b1;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_adc",  32'(adc_enable), 32'd1);
    eoc_on(12'h800);
    check("t1_v0", 32'(valid), 32'd1);
    check("t1_d0", 32'(data_out), 32'h800);
    eoc_off();
    check("t1_pop0", 32'(valid), 32'd0);
    eoc_on(12'h001);
    check("t1_d1", 32'(data_out), 32'h001);
    eoc_off();
    eoc_on(12'hFFF);
    check("t1_d2",    32'(data_out),   32'hFFF);
    check("t1_bdone", 32'(burst_done), 32'd1);
    check("t1_adc_off", 32'(adc_enable), 32'd0);
    eoc_off();
    check("t1_idle",   32'(busy),     32'd0);
    check("t1_bcount", 32'(bd_count), 32'd1);
    check("t1_hold",   32'(data_out), 32'hFFF);

    // EOC held high for five cycles yields one push
    ready = 1'b0; cont = 1'b1;
    pulse_start();
    eoc_on(12'h0A5);
    for (int i = 0; i < 4; i++) tick();
    eoc_off();
    check("t2_level", 32'(level),    32'd1);
    check("t2_data",  32'(data_out), 32'h0A5);
    pulse_stop();
    check("t2_stop",   32'(busy),     32'd0);
    check("t2_bcount", 32'(bd_count), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t2_drain", 32'(level), 32'd0);

    // Overflow: 10 events into an 8-deep FIFO
    cont = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      eoc_on(12'(i));
      eoc_off();
    end
    check("t3_level", 32'(level), 32'd8);
    check("t3_ovf",   32'(ovf),   32'd1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_drain%0d", i), 32'(data_out), 32'(i));
      tick();
    end
    ready = 1'b0;
    check("t3_empty", 32'(valid), 32'd0);
    pulse_stop();
    check("t3_sticky", 32'(ovf), 32'd1);
    pulse_start();
    check("t3_ovf_clr", 32'(ovf),  32'd0);
    check("t3_busy",    32'(busy), 32'd1);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) begin
      eoc_on(12'h010 + 12'(i));
      eoc_off();
      exp_q.push_back(12'h010 + 12'(i));
    end
    check("t4_full", 32'(level), 32'd8);
    set_dout(12'h123);
    eoc = 1'b1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    eoc = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(12'h123);
    check("t4_level", 32'(level), 32'd8);
    check("t4_ovf",   32'(ovf),   32'd0);
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("t4_drain", 32'(data_out), 32'(exp_q.pop_front()));
      tick();
    end
    ready = 1'b0;
    check("t4_empty", 32'(valid), 32'd0);
    pulse_stop();

    // STOP mid-burst; the 4th EOC rises together with STOP
    cont = 1'b0; num_samples = 16'd10;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      eoc_on(12'h200 + 12'(i));
      eoc_off();
    end
    set_dout(12'h203);
    eoc = 1'b1;
    stop = 1'b1;
    tick();
    eoc = 1'b0;
    stop = 1'b0;
    check("t5_idle",  32'(busy),       32'd0);
    check("t5_level", 32'(level),      32'd4);
    check("t5_head",  32'(data_out),   32'h200);
    check("t5_bdone", 32'(burst_done), 32'd0);
    tick();
    check("t5_bcount", 32'(bd_count), 32'd1);

    // NUM_SAMPLES=0 behaves as 1
    num_samples = 16'd0;
    pulse_start();
    eoc_on(12'h0AA);
    check("t6_bdone", 32'(burst_done), 32'd1);
    eoc_off();
    check("t6_idle",   32'(busy),     32'd0);
    check("t6_bcount", 32'(bd_count), 32'd2);
    check("t6_level",  32'(level),    32'd5);

    // Reset in the middle of a burst
    num_samples = 16'd10;
    pulse_start();
    eoc_on(12'h555);
    eoc_off();
    check("t7_busy",  32'(busy),  32'd1);
    check("t7_level", 32'(level), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("t7_rst");

`ifdef SAR_READER_AVG_EN
    // Averaging: four events average to one pushed word
    num_samples = 16'd1; cont = 1'b0; ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      eoc_on(12'd100 + 12'(i));
      eoc_off();
    end
    check("avg_partial", 32'(level), 32'd0);
    eoc_on(12'd103);
    check("avg_level", 32'(level),      32'd1);
    check("avg_data",  32'(data_out),   32'd101);
    check("avg_bdone", 32'(burst_done), 32'd1);
    eoc_off();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
